// File: rtl/outport_buffered_if.sv
// ---------------------------------------------------------------------------
// outport_buffered_if
// Bundles the crossbar-side and link-side signals of the buffered output port.
//   toggle_din      crossbar write strobe, one flit per cycle when high
//   crossbar_din    flit from the crossbar, sampled when toggle_din is high
//   credit_din      one-cycle credit return from downstream, one slot per pulse
//   diff_pair_dout  [1]=p, [0]=n complementary toggle pair, flips per launch
//   channel_dout    registered flit driven onto the link
//   full_dout       FIFO full; the crossbar must not write while high
//   credits_dout    current downstream credit count
//   overflow_dout   sticky flag: a write was attempted while full
// Modport master is the crossbar/link environment; modport slave is the port.
// ---------------------------------------------------------------------------
interface outport_buffered_if #(
    parameter int DATA_WIDTH = 48,
    parameter int CNT_W      = 3
);
    logic                  toggle_din;
    logic [DATA_WIDTH-1:0] crossbar_din;
    logic                  credit_din;
    logic [1:0]            diff_pair_dout;
    logic [DATA_WIDTH-1:0] channel_dout;
    logic                  full_dout;
    logic [CNT_W-1:0]      credits_dout;
    logic                  overflow_dout;

    modport master (
        output toggle_din,
        output crossbar_din,
        output credit_din,
        input  diff_pair_dout,
        input  channel_dout,
        input  full_dout,
        input  credits_dout,
        input  overflow_dout
    );

    modport slave (
        input  toggle_din,
        input  crossbar_din,
        input  credit_din,
        output diff_pair_dout,
        output channel_dout,
        output full_dout,
        output credits_dout,
        output overflow_dout
    );
endinterface

// File: rtl/outport_buffered.sv
// ---------------------------------------------------------------------------
// outport_buffered
// Credit-controlled output port between the crossbar and a link channel.
// Crossbar flits are buffered in a DEPTH-entry FIFO; at most one flit per
// cycle is launched onto the registered channel when the FIFO holds data and
// at least one downstream credit is available. Each launch flips the
// complementary toggle pair and consumes one credit.
// Ports:
//   clka  clock, all state on the rising edge
//   rsta  asynchronous active-low reset
//   bus   outport_buffered_if.slave (crossbar input, link output, status)
// ---------------------------------------------------------------------------
module outport_buffered #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 4,
    parameter int CREDITS    = 4,
    parameter int CNT_W      = 3
) (
    input  logic                clka,
    input  logic                rsta,
    outport_buffered_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    // Extra pointer bit distinguishes a full FIFO from an empty one.
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [DATA_WIDTH-1:0] channel_q,  channel_d;
    logic [1:0]            pair_q,     pair_d;
    logic                  full_q,     full_d;
    logic [CNT_W-1:0]      credits_q,  credits_d;
    logic                  overflow_q, overflow_d;

    logic [PW-1:0]         occ_s;
    logic [PW-1:0]         occ_next_s;
    logic                  empty_s;
    logic                  launch_s;
    logic                  push_s;

    // Launch/push decisions and next-state values for pointers and outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        channel_d  = channel_q;
        pair_d     = pair_q;
        credits_d  = credits_q;
        overflow_d = overflow_q;

        occ_s    = wr_ptr_q - rd_ptr_q;
        empty_s  = (occ_s == {PW{1'b0}});
        launch_s = !empty_s && (credits_q != {CNT_W{1'b0}});
        // A launch frees the head slot on the same edge, so a write into a
        // full FIFO is still accepted when a launch happens alongside it.
        push_s   = bus.toggle_din && (!full_q || launch_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (launch_s) begin
            rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            channel_d = mem_q[rd_ptr_q[AW-1:0]];
            pair_d    = ~pair_q;
        end else begin
            rd_ptr_d  = rd_ptr_q;
            channel_d = channel_q;
            pair_d    = pair_q;
        end

        if (bus.toggle_din && full_q && !launch_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case ({launch_s, bus.credit_din})
            2'b10: credits_d = credits_q - {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01: begin
                // Returns beyond the maximum saturate silently.
                if (credits_q == CNT_W'(CREDITS)) begin
                    credits_d = credits_q;
                end else begin
                    credits_d = credits_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: credits_d = credits_q;
        endcase

        occ_next_s = occ_s + PW'(push_s) - PW'(launch_s);
        full_d     = (occ_next_s == PW'(DEPTH));
    end

    // Pointer, status and link output registers.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            channel_q  <= {DATA_WIDTH{1'b0}};
            pair_q     <= 2'b01;
            full_q     <= 1'b0;
            credits_q  <= CNT_W'(CREDITS);
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            channel_q  <= channel_d;
            pair_q     <= pair_d;
            full_q     <= full_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clka) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.crossbar_din;
        end
    end

    assign bus.channel_dout   = channel_q;
    assign bus.diff_pair_dout = pair_q;
    assign bus.full_dout      = full_q;
    assign bus.credits_dout   = credits_q;
    assign bus.overflow_dout  = overflow_q;

endmodule

// File: tb/tb_outport_buffered.sv
// ---------------------------------------------------------------------------
// tb_outport_buffered
// Directed and random stimulus for outport_buffered, compared each cycle
// against a queue-based reference model of the port's behaviour.
// ---------------------------------------------------------------------------
module tb_outport_buffered;

    localparam int DW      = 48;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int CNT_W   = 3;

    logic clka;
    logic rsta;

    outport_buffered_if #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) bus ();

    outport_buffered #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .CREDITS(CREDITS),
        .CNT_W(CNT_W)
    ) dut (
        .clka(clka),
        .rsta(rsta),
        .bus(bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] q_m [$];
    logic [DW-1:0] chan_m;
    logic [1:0]    pair_m;
    int            cred_m;
    logic          ovf_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        chan_m = '0;
        pair_m = 2'b01;
        cred_m = CREDITS;
        ovf_m  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".channel"},  64'(bus.channel_dout),   64'(chan_m));
        check({tag, ".pair"},     64'(bus.diff_pair_dout), 64'(pair_m));
        check({tag, ".full"},     64'(bus.full_dout),      64'(q_m.size() == DEPTH));
        check({tag, ".credits"},  64'(bus.credits_dout),   64'(cred_m));
        check({tag, ".overflow"}, 64'(bus.overflow_dout),  64'(ovf_m));
    endtask

    // One clock of stimulus; the model is advanced from its pre-edge state.
    task automatic step(input string tag, input logic tog, input logic [DW-1:0] d, input logic cr);
        bit launch;
        bit full;
        bus.toggle_din   = tog;
        bus.crossbar_din = d;
        bus.credit_din   = cr;
        @(posedge clka);
        launch = (q_m.size() > 0) && (cred_m > 0);
        full   = (q_m.size() == DEPTH);
        if (launch) begin
            chan_m = q_m.pop_front();
            pair_m = ~pair_m;
        end
        if (tog) begin
            if (!full || launch) q_m.push_back(d);
            else ovf_m = 1'b1;
        end
        if (launch && !cr) cred_m--;
        else if (cr && !launch && cred_m < CREDITS) cred_m++;
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        bus.toggle_din   = 1'b0;
        bus.crossbar_din = '0;
        bus.credit_din   = 1'b0;
        rsta = 1'b0;
        model_reset();
        repeat (2) @(posedge clka);
        @(negedge clka);
        check_all("reset");
        rsta = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rnd;
        model_reset();
        rsta = 1'b1;
        bus.toggle_din   = 1'b0;
        bus.crossbar_din = '0;
        bus.credit_din   = 1'b0;
        #2;
        do_reset();

        // Single push, launched one edge later
        step("single_push", 1'b1, 48'hA5A5_0000_0001, 1'b0);
        step("single_launch", 1'b0, '0, 1'b0);
        check("single.chan", 64'(bus.channel_dout), 64'h0000_A5A5_0000_0001);
        check("single.pair", 64'(bus.diff_pair_dout), 64'h2);
        check("single.cred", 64'(bus.credits_dout), 64'h3);

        // Four back-to-back flits drain all credits
        do_reset();
        for (int i = 1; i <= 4; i++) step("burst", 1'b1, DW'(i), 1'b0);
        step("burst_tail", 1'b0, '0, 1'b0);
        check("burst.chan", 64'(bus.channel_dout), 64'h4);
        check("burst.pair", 64'(bus.diff_pair_dout), 64'h1);
        check("burst.cred", 64'(bus.credits_dout), 64'h0);

        // No credits: flit 5 waits for a credit return
        step("nocred_push", 1'b1, 48'h5, 1'b0);
        step("nocred_hold", 1'b0, '0, 1'b0);
        check("nocred.chan", 64'(bus.channel_dout), 64'h4);
        step("credit_ret", 1'b0, '0, 1'b1);
        check("credit_ret.cred", 64'(bus.credits_dout), 64'h1);
        step("resume", 1'b0, '0, 1'b0);
        check("resume.chan", 64'(bus.channel_dout), 64'h5);
        check("resume.cred", 64'(bus.credits_dout), 64'h0);

        // Overflow: six pushes into a four-entry FIFO with no credits
        do_reset();
        for (int i = 1; i <= 4; i++) step("pre_drain", 1'b1, DW'(i), 1'b0);
        step("pre_drain_tail", 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step("ovf_push", 1'b1, DW'(48'h10 + i), 1'b0);
        check("ovf.full", 64'(bus.full_dout), 64'h1);
        check("ovf.flag", 64'(bus.overflow_dout), 64'h1);
        for (int i = 0; i < 6; i++) begin
            step("drain_cr", 1'b0, '0, 1'b1);
            step("drain", 1'b0, '0, 1'b0);
        end
        check("drain.chan", 64'(bus.channel_dout), 64'h13);
        check("drain.full", 64'(bus.full_dout), 64'h0);
        check("drain.flag", 64'(bus.overflow_dout), 64'h1);

        // Full FIFO with one credit: simultaneous push and launch
        do_reset();
        for (int i = 1; i <= 4; i++) step("fill_a", 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 4; i++) step("fill_b", 1'b1, DW'(48'h20 + i), 1'b0);
        check("fill.full", 64'(bus.full_dout), 64'h1);
        step("one_cred", 1'b0, '0, 1'b1);
        step("push_launch", 1'b1, 48'h30, 1'b0);
        check("pl.chan", 64'(bus.channel_dout), 64'h20);
        check("pl.full", 64'(bus.full_dout), 64'h1);
        check("pl.flag", 64'(bus.overflow_dout), 64'h0);

        // Asynchronous reset between edges mid-burst
        do_reset();
        step("mid_a", 1'b1, 48'h41, 1'b0);
        step("mid_b", 1'b1, 48'h42, 1'b0);
        #2;
        rsta = 1'b0;
        bus.toggle_din = 1'b0;
        model_reset();
        #1;
        check("async.chan", 64'(bus.channel_dout), 64'h0);
        check("async.pair", 64'(bus.diff_pair_dout), 64'h1);
        check("async.cred", 64'(bus.credits_dout), 64'h4);
        check("async.full", 64'(bus.full_dout), 64'h0);
        @(negedge clka);
        rsta = 1'b1;
        step("post_push", 1'b1, 48'h99, 1'b0);
        step("post_launch", 1'b0, '0, 1'b0);
        check("post.chan", 64'(bus.channel_dout), 64'h99);
        step("post_idle", 1'b0, '0, 1'b0);
        check("post.idle_chan", 64'(bus.channel_dout), 64'h99);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rnd = {16'($urandom), $urandom};
            step("rand", ($urandom_range(0, 99) < 60), rnd, ($urandom_range(0, 99) < 45));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
